button_gesture: RTL and testbench

- Consumes the stable level from the upstream switch debouncer and classifies button activity into single-cycle event pulses: press, release, short press, long press and double press.
- Sits between the debouncer output and the control logic: mode switching, record start/stop and calibration triggers.
- Registered outputs only; all timing is in clk cycles.

---
 rtl/button_gesture.sv | 173 +++++++++++++++++
 tb/tb_button_gesture.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_gesture.sv
// Classifies a debounced button level into press/release/short/long/double one-cycle pulses.
// Define BUTTON_GESTURE_AUTOREPEAT_EN to add repeat_pulse autorepeat while a long press is held.
module button_gesture #(
    parameter int   LONG_CYCLES   = 50000000,
    parameter int   DOUBLE_CYCLES = 15000000,
    parameter int   REPEAT_CYCLES = 10000000,
    parameter logic ACTIVE_LEVEL  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_pulse
);

    localparam int MAX_LD  = (LONG_CYCLES > DOUBLE_CYCLES) ? LONG_CYCLES : DOUBLE_CYCLES;
    localparam int MAX_ALL = (MAX_LD > REPEAT_CYCLES) ? MAX_LD : REPEAT_CYCLES;
    localparam int CW      = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] LONG_C   = CW'(LONG_CYCLES);
    localparam logic [CW-1:0] DOUBLE_C = CW'(DOUBLE_CYCLES);
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
    localparam logic [CW-1:0] REPEAT_C = CW'(REPEAT_CYCLES);
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HELD1 = 3'd1,
        LONG  = 3'd2,
        GAP   = 3'd3,
        HELD2 = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] cnt_inc;
    logic          in_q;
    logic          lvl;
    logic          lvl_prev;
    logic          short_next;
    logic          long_next;
    logic          double_next;
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
    logic          repeat_next;
`endif

    assign lvl     = (in_q == ACTIVE_LEVEL);
    // lvl_prev is lvl delayed by one edge, which is exactly the pressed level.
    assign pressed = lvl_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= CNT_ZERO;
            in_q          <= ~ACTIVE_LEVEL;
            lvl_prev      <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            double_press  <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            in_q          <= in;
            lvl_prev      <= lvl;
            press_pulse   <= lvl & ~lvl_prev;
            release_pulse <= ~lvl & lvl_prev;
            short_press   <= short_next;
            long_press    <= long_next;
            double_press  <= double_next;
        end
    end

`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= repeat_next;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        short_next  = 1'b0;
        long_next   = 1'b0;
        double_next = 1'b0;
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
        repeat_next = 1'b0;
`endif
        // Saturating increment so the counter can never wrap.
        cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

        case (state)
            IDLE: begin
                if (lvl) begin
                    state_next = HELD1;
                    cnt_next   = CNT_ONE;
                end
            end
            HELD1: begin
                if (!lvl) begin
                    state_next = GAP;
                    cnt_next   = CNT_ONE;
                end else if (cnt_inc >= LONG_C) begin
                    long_next  = 1'b1;
                    state_next = LONG;
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
                    cnt_next   = CNT_ONE;
`else
                    cnt_next   = CNT_ZERO;
`endif
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            LONG: begin
                if (!lvl) begin
                    state_next = IDLE;
                    cnt_next   = CNT_ZERO;
                end
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
                // Counter already sits at the period value when the repeat is decided.
                else if (cnt >= REPEAT_C) begin
                    repeat_next = 1'b1;
                    cnt_next    = CNT_ONE;
                end else begin
                    cnt_next = cnt_inc;
                end
`endif
            end
            GAP: begin
                if (lvl) begin
                    state_next = HELD2;
                    cnt_next   = CNT_ZERO;
                end else if (cnt_inc >= DOUBLE_C) begin
                    short_next = 1'b1;
                    state_next = IDLE;
                    cnt_next   = CNT_ZERO;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            HELD2: begin
                if (!lvl) begin
                    double_next = 1'b1;
                    state_next  = IDLE;
                    cnt_next    = CNT_ZERO;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = CNT_ZERO;
            end
        endcase
    end

endmodule

// File: tb/tb_button_gesture.sv
// Scoreboard bench for button_gesture: directed gestures push expected events, a monitor pops them.
// Event entries are packed as (absolute edge << 3) | event code.
module tb_button_gesture;

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_SHORT   = 2;
    localparam int EV_LONG    = 3;
    localparam int EV_DOUBLE  = 4;
    localparam int EV_REPEAT  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in  = 1'b0;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic short_press;
    logic long_press;
    logic double_press;
    logic repeat_pulse;

    int edge_cnt     = 0;
    int base         = 0;
    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    button_gesture #(
        .LONG_CYCLES  (8),
        .DOUBLE_CYCLES(4),
        .REPEAT_CYCLES(3),
        .ACTIVE_LEVEL (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in           (in),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_press (double_press),
        .repeat_pulse (repeat_pulse)
    );

    // Clock and edge numbering
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic string ev_name(input int c);
        case (c)
            EV_PRESS:   return "press_pulse";
            EV_RELEASE: return "release_pulse";
            EV_SHORT:   return "short_press";
            EV_LONG:    return "long_press";
            EV_DOUBLE:  return "double_press";
            EV_REPEAT:  return "repeat_pulse";
            default:    return "unknown";
        endcase
    endfunction

    function automatic int out_vec();
        return int'({pressed, press_pulse, release_pulse, short_press,
                     long_press, double_press, repeat_pulse});
    endfunction

    task automatic check(input string name, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (scenario edge %0d)",
                     name, got, exp, edge_cnt - base);
        end
    endtask

    task automatic expect_ev(input int rel, input int code);
        exp_q.push_back((32'(base + rel) << 3) | 32'(code));
    endtask

    task automatic check_drain(input string name);
        check({name, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: every pulse seen must match the head of the expected queue.
    task automatic monitor();
        logic [5:0]  pv;
        logic [31:0] got;
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            pv = {repeat_pulse, double_press, long_press, short_press, release_pulse, press_pulse};
            for (int c = 0; c < 6; c++) begin
                if (pv[c]) begin
                    got = (32'(edge_cnt) << 3) | 32'(c);
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL event: got %s at edge %0d, expected no event",
                                 ev_name(c), edge_cnt - base);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            tests_failed++;
                            $display("FAIL event: got %s at edge %0d, expected %s at edge %0d",
                                     ev_name(c), edge_cnt - base,
                                     ev_name(int'(exp[2:0])), int'(exp >> 3) - base);
                        end
                    end
                end
            end
        end
    endtask

    // Driver: in is set before edge e so in_q captures it at scenario edge e.
    task automatic run_scn(input string name, input int hi1, input int lo1,
                           input int hi2, input int lo2, input int len);
        for (int e = 1; e <= len; e++) begin
            in = ((e >= hi1) && (e < lo1)) ||
                 ((hi2 > 0) && (e >= hi2) && ((lo2 == 0) || (e < lo2)));
            @(negedge clk);
            if (e == hi1)     check({name, "_pressed_before"}, int'(pressed), 0);
            if (e == hi1 + 1) check({name, "_pressed_on"},     int'(pressed), 1);
            if (e == lo1 + 1) check({name, "_pressed_off"},    int'(pressed), 0);
        end
        in = 1'b0;
        check_drain(name);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset
        rst = 1'b1;
        in  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_outputs", out_vec(), 0);

        // Short press
        base = edge_cnt;
        expect_ev(11, EV_PRESS);
        expect_ev(14, EV_RELEASE);
        expect_ev(17, EV_SHORT);
        run_scn("short", 10, 13, 0, 0, 25);

        // Long press
        base = edge_cnt;
        expect_ev(11, EV_PRESS);
        expect_ev(18, EV_LONG);
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
        expect_ev(21, EV_REPEAT);
        expect_ev(24, EV_REPEAT);
        expect_ev(27, EV_REPEAT);
        expect_ev(30, EV_REPEAT);
`endif
        expect_ev(31, EV_RELEASE);
        run_scn("long", 10, 30, 0, 0, 40);

        // Double press
        base = edge_cnt;
        expect_ev(11, EV_PRESS);
        expect_ev(14, EV_RELEASE);
        expect_ev(16, EV_PRESS);
        expect_ev(19, EV_RELEASE);
        expect_ev(19, EV_DOUBLE);
        run_scn("double", 10, 13, 15, 18, 30);

        // Gap boundary: second press lands one cycle too late, so it is a fresh HELD1
        base = edge_cnt;
        expect_ev(11, EV_PRESS);
        expect_ev(14, EV_RELEASE);
        expect_ev(17, EV_SHORT);
        expect_ev(18, EV_PRESS);
        expect_ev(21, EV_RELEASE);
        expect_ev(24, EV_SHORT);
        run_scn("gap_edge", 10, 13, 17, 20, 32);

        // Press-length boundary: 7 active cycles stays short
        base = edge_cnt;
        expect_ev(11, EV_PRESS);
        expect_ev(18, EV_RELEASE);
        expect_ev(21, EV_SHORT);
        run_scn("len7", 10, 17, 0, 0, 30);

        // Press-length boundary: 8 active cycles is long
        base = edge_cnt;
        expect_ev(11, EV_PRESS);
        expect_ev(18, EV_LONG);
        expect_ev(19, EV_RELEASE);
        run_scn("len8", 10, 18, 0, 0, 30);

        // Reset in the middle of a long press, button held through deassertion
        base = edge_cnt;
        expect_ev(11, EV_PRESS);
        for (int e = 1; e <= 12; e++) begin
            in = (e >= 10);
            @(negedge clk);
        end
        check("rst_mid_pressed", int'(pressed), 1);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", out_vec(), 0);
        @(negedge clk);
        rst = 1'b0;
        expect_ev(15, EV_PRESS);
        expect_ev(22, EV_LONG);
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
        expect_ev(25, EV_REPEAT);
`endif
        expect_ev(26, EV_RELEASE);
        for (int e = 14; e <= 40; e++) begin
            in = (e < 25);
            @(negedge clk);
            if (e == 14) check("rst_mid_pressed_after", int'(pressed), 0);
        end
        in = 1'b0;
        check_drain("rst_mid");

        repeat (5) @(negedge clk);
        check("final_idle_outputs", out_vec(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
